// File: rtl/inst_rom_loader.sv
// rtl/inst_rom_loader.sv - instruction ROM with byte-serial boot loader
// Fetch port reads combinationally; the loader packs bytes big-endian and commits one word per WRITE cycle.
module inst_rom_loader #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce_i,
    input  logic [31:0]           addr_i,
    output logic [31:0]           inst_o,
    input  logic                  ld_start_i,
    input  logic [DEPTH_LOG2-1:0] ld_base_i,
    input  logic                  ld_valid_i,
    input  logic [7:0]            ld_byte_i,
    input  logic                  ld_last_i,
    output logic                  ld_ready_o,
    output logic                  ld_busy_o,
    output logic [DEPTH_LOG2:0]   ld_count_o,
    output logic                  ld_err_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  err_q, err_d;
    logic [1:0]            bcnt_q, bcnt_d;
    logic [31:0]           shift_q, shift_d;
    logic                  last_q, last_d;
    logic                  mem_we;
    logic                  room;

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            wptr_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            bcnt_q  <= 2'd0;
            shift_q <= 32'd0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            err_q   <= err_d;
            bcnt_q  <= bcnt_d;
            shift_q <= shift_d;
            last_q  <= last_d;
        end
    end

    assign room = (count_q < DEPTH_CNT);

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        err_d   = err_q;
        bcnt_d  = bcnt_q;
        shift_d = shift_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: begin
                if (ld_start_i) begin
                    state_d = S_COLLECT;
                    wptr_d  = ld_base_i;
                    count_d = '0;
                    err_d   = 1'b0;
                    bcnt_d  = 2'd0;
                    shift_d = 32'd0;
                    last_d  = 1'b0;
                end
            end
            S_COLLECT: begin
                if (ld_valid_i) begin
                    // byte k of a word lands at bits [31-8k -: 8]
                    shift_d = shift_q | ({24'd0, ld_byte_i} << {~bcnt_q, 3'b000});
                    bcnt_d  = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3 || ld_last_i) begin
                        state_d = S_WRITE;
                        last_d  = ld_last_i;
                    end
                    if (ld_last_i && bcnt_q != 2'd3) begin
                        err_d = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                if (room) begin
                    wptr_d  = wptr_q + 1'b1;
                    count_d = count_q + 1'b1;
                end else begin
                    err_d = 1'b1;
                end
                bcnt_d  = 2'd0;
                shift_d = 32'd0;
                state_d = last_q ? S_IDLE : S_COLLECT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ld_ready_o = 1'b0;
        ld_busy_o  = 1'b0;
        mem_we     = 1'b0;
        case (state_q)
            S_COLLECT: begin
                ld_ready_o = 1'b1;
                ld_busy_o  = 1'b1;
            end
            S_WRITE: begin
                ld_busy_o = 1'b1;
                mem_we    = room;
            end
            default: begin
                ld_ready_o = 1'b0;
                ld_busy_o  = 1'b0;
            end
        endcase
    end

    assign ld_count_o = count_q;
    assign ld_err_o   = err_q;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wptr_q] <= shift_q;
        end
    end

    // Fetches see NOP during a session so the core idles while memory is being rewritten
    assign inst_o = (ce_i && !ld_busy_o) ? mem[addr_i[DEPTH_LOG2+1:2]] : 32'd0;

    logic unused_addr;
    assign unused_addr = ^{addr_i[31:DEPTH_LOG2+2], addr_i[1:0]};

endmodule

// File: tb/tb_inst_rom_loader.sv
// tb/tb_inst_rom_loader.sv - directed self-checking bench for inst_rom_loader
module tb_inst_rom_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        ce = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] inst;
    logic        ld_start = 1'b0;
    logic [9:0]  ld_base = 10'd0;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_byte = 8'd0;
    logic        ld_last = 1'b0;
    logic        ld_ready, ld_busy, ld_err;
    logic [10:0] ld_count;

    logic        ce2 = 1'b0;
    logic [31:0] addr2 = 32'd0;
    logic [31:0] inst2;
    logic        ld2_start = 1'b0;
    logic [1:0]  ld2_base = 2'd0;
    logic        ld2_valid = 1'b0;
    logic [7:0]  ld2_byte = 8'd0;
    logic        ld2_last = 1'b0;
    logic        ld2_ready, ld2_busy, ld2_err;
    logic [2:0]  ld2_count;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    inst_rom_loader #(.DEPTH_LOG2(10)) u_dut (
        .clk(clk), .rst(rst), .ce_i(ce), .addr_i(addr), .inst_o(inst),
        .ld_start_i(ld_start), .ld_base_i(ld_base), .ld_valid_i(ld_valid),
        .ld_byte_i(ld_byte), .ld_last_i(ld_last), .ld_ready_o(ld_ready),
        .ld_busy_o(ld_busy), .ld_count_o(ld_count), .ld_err_o(ld_err)
    );

    inst_rom_loader #(.DEPTH_LOG2(2)) u_small (
        .clk(clk), .rst(rst), .ce_i(ce2), .addr_i(addr2), .inst_o(inst2),
        .ld_start_i(ld2_start), .ld_base_i(ld2_base), .ld_valid_i(ld2_valid),
        .ld_byte_i(ld2_byte), .ld_last_i(ld2_last), .ld_ready_o(ld2_ready),
        .ld_busy_o(ld2_busy), .ld_count_o(ld2_count), .ld_err_o(ld2_err)
    );

    task automatic start(input bit sel, input logic [9:0] base);
        if (!sel) begin ld_start = 1'b1; ld_base = base; end
        else begin ld2_start = 1'b1; ld2_base = base[1:0]; end
        @(posedge clk); #1;
        ld_start = 1'b0;
        ld2_start = 1'b0;
    endtask

    // returns 1 time unit after the edge that accepted the byte
    task automatic send_byte(input bit sel, input logic [7:0] b, input bit last);
        int n;
        n = 0;
        if (!sel) begin ld_valid = 1'b1; ld_byte = b; ld_last = last; end
        else begin ld2_valid = 1'b1; ld2_byte = b; ld2_last = last; end
        while (!(sel ? ld2_ready : ld_ready) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            $display("FAIL send_timeout ld_ready stayed 0 for %0d cycles", n);
            $fatal(1);
        end
        @(posedge clk); #1;
        ld_valid = 1'b0; ld_last = 1'b0;
        ld2_valid = 1'b0; ld2_last = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total_cnt++;
        if ({ld_ready, ld_busy, ld_err} !== 3'b000) $display("FAIL reset_flags got %b want 000", {ld_ready, ld_busy, ld_err});
        else pass_cnt++;
        total_cnt++;
        if (ld_count !== 11'd0) $display("FAIL reset_count got %0d want 0", ld_count);
        else pass_cnt++;
        ce = 1'b0; addr = 32'd0; #1;
        total_cnt++;
        if (inst !== 32'd0) $display("FAIL reset_ce0 got %h want 00000000", inst);
        else pass_cnt++;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_load_basic();
        logic [7:0] bytes [8];
        bytes = '{8'h3C, 8'h01, 8'h12, 8'h34, 8'h34, 8'h21, 8'h00, 8'hFF};
        start(1'b0, 10'd0);
        for (int i = 0; i < 8; i++) begin
            send_byte(1'b0, bytes[i], i == 7);
            if (i == 5) begin
                ce = 1'b1; addr = 32'h0; #1;
                total_cnt++;
                if (inst !== 32'd0) $display("FAIL busy_fetch_nop got %h want 00000000", inst);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if ({ld_busy, ld_ready} !== 2'b10) $display("FAIL write_cycle_flags got %b want 10", {ld_busy, ld_ready});
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (ld_busy !== 1'b0) $display("FAIL busy_after_last got %b want 0", ld_busy);
        else pass_cnt++;
        total_cnt++;
        if ({ld_count, ld_err} !== {11'd2, 1'b0}) $display("FAIL basic_count_err got %0d/%b want 2/0", ld_count, ld_err);
        else pass_cnt++;
        ce = 1'b1; addr = 32'h0; #1;
        total_cnt++;
        if (inst !== 32'h3C011234) $display("FAIL fetch_0 got %h want 3C011234", inst);
        else pass_cnt++;
        addr = 32'h4; #1;
        total_cnt++;
        if (inst !== 32'h342100FF) $display("FAIL fetch_4 got %h want 342100FF", inst);
        else pass_cnt++;
        ce = 1'b0; #1;
        total_cnt++;
        if (inst !== 32'd0) $display("FAIL fetch_ce0 got %h want 00000000", inst);
        else pass_cnt++;
    endtask

    task automatic test_early_last();
        start(1'b0, 10'd5);
        send_byte(1'b0, 8'hAA, 1'b0);
        send_byte(1'b0, 8'hBB, 1'b0);
        send_byte(1'b0, 8'hCC, 1'b1);
        @(posedge clk); #1;
        total_cnt++;
        if ({ld_busy, ld_count, ld_err} !== {1'b0, 11'd1, 1'b1})
            $display("FAIL early_last_status got busy=%b count=%0d err=%b want 0/1/1", ld_busy, ld_count, ld_err);
        else pass_cnt++;
        ce = 1'b1; addr = 32'h14; #1;
        total_cnt++;
        if (inst !== 32'hAABBCC00) $display("FAIL early_last_word got %h want AABBCC00", inst);
        else pass_cnt++;
        ce = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [8];
        logic [8:0] rdy_trace;
        int idx, cyc;
        bit rdy_seen;
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        start(1'b0, 10'd8);
        ld_base = 10'd0;
        rdy_trace = '0;
        idx = 0; cyc = 0;
        ld_valid = 1'b1;
        while (idx < 8 && cyc < 40) begin
            ld_byte = bytes[idx];
            ld_last = (idx == 7);
            ld_start = (cyc == 3 || cyc == 4 || cyc == 6);
            rdy_seen = ld_ready;
            if (cyc < 9) rdy_trace[8 - cyc] = rdy_seen;
            @(posedge clk);
            if (rdy_seen) idx++;
            cyc++;
            #1;
        end
        ld_valid = 1'b0; ld_last = 1'b0; ld_start = 1'b0;
        total_cnt++;
        if (cyc !== 9) $display("FAIL handshake_cycles got %0d want 9", cyc);
        else pass_cnt++;
        total_cnt++;
        if (rdy_trace !== 9'b111101111) $display("FAIL handshake_ready_trace got %b want 111101111", rdy_trace);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if ({ld_busy, ld_count, ld_err} !== {1'b0, 11'd2, 1'b0})
            $display("FAIL b2b_status got busy=%b count=%0d err=%b want 0/2/0", ld_busy, ld_count, ld_err);
        else pass_cnt++;
        ce = 1'b1; addr = 32'h20; #1;
        total_cnt++;
        if (inst !== 32'h11223344) $display("FAIL b2b_word8 got %h want 11223344", inst);
        else pass_cnt++;
        addr = 32'h24; #1;
        total_cnt++;
        if (inst !== 32'h55667788) $display("FAIL b2b_word9 got %h want 55667788", inst);
        else pass_cnt++;
        addr = 32'h0; #1;
        total_cnt++;
        if (inst !== 32'h3C011234) $display("FAIL b2b_word0_kept got %h want 3C011234", inst);
        else pass_cnt++;
        ce = 1'b0;
    endtask

    task automatic test_overflow();
        logic [31:0] words [5];
        logic [31:0] w;
        words = '{32'h01020304, 32'h11121314, 32'h21222324, 32'h31323334, 32'h41424344};
        start(1'b1, 10'd3);
        for (int k = 0; k < 5; k++) begin
            w = words[k];
            for (int j = 0; j < 4; j++) send_byte(1'b1, w[31 - 8*j -: 8], (k == 4) && (j == 3));
            if (k == 3) begin
                @(posedge clk); #1;
                total_cnt++;
                if ({ld2_count, ld2_err} !== {3'd4, 1'b0}) $display("FAIL ovf_full_no_err got %0d/%b want 4/0", ld2_count, ld2_err);
                else pass_cnt++;
            end
        end
        @(posedge clk); #1;
        total_cnt++;
        if ({ld2_busy, ld2_count, ld2_err} !== {1'b0, 3'd4, 1'b1})
            $display("FAIL ovf_status got busy=%b count=%0d err=%b want 0/4/1", ld2_busy, ld2_count, ld2_err);
        else pass_cnt++;
        ce2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr2 = 32'(i * 4); #1;
            total_cnt++;
            if (inst2 !== words[(i + 1) % 4]) $display("FAIL ovf_word%0d got %h want %h", i, inst2, words[(i + 1) % 4]);
            else pass_cnt++;
        end
        ce2 = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [7:0] bytes [6];
        bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hCA, 8'hFE};
        start(1'b0, 10'd0);
        for (int i = 0; i < 6; i++) send_byte(1'b0, bytes[i], 1'b0);
        rst = 1'b0; #1;
        total_cnt++;
        if ({ld_ready, ld_busy, ld_err, ld_count} !== {3'b000, 11'd0})
            $display("FAIL async_reset got rdy=%b busy=%b err=%b count=%0d want 0/0/0/0", ld_ready, ld_busy, ld_err, ld_count);
        else pass_cnt++;
        #3; rst = 1'b1;
        @(posedge clk); #1;
        ce = 1'b1; addr = 32'h1000; #1;
        total_cnt++;
        if (inst !== 32'hDEADBEEF) $display("FAIL alias_1000 got %h want DEADBEEF", inst);
        else pass_cnt++;
        addr = 32'h4; #1;
        total_cnt++;
        if (inst !== 32'h342100FF) $display("FAIL partial_discarded got %h want 342100FF", inst);
        else pass_cnt++;
        ce = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_early_last();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/inst_rom_loader.md
Name: inst_rom_loader

Overview:
Instruction-memory responder for the core's fetch port: it answers ce_i/addr_i with a 32-bit instruction word in the same cycle. A byte-serial load port with a valid/ready handshake fills the memory through a state machine. The state machine packs bytes big-endian into words and commits one word per WRITE cycle. Fetches return NOP (0x00000000) while a load session is active, so the core idles safely during boot loading.

Parameters:
DEPTH_LOG2, 10, log2 of memory depth in 32-bit words (DEPTH = 2**DEPTH_LOG2)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
ce_i  in  1  fetch enable from core
addr_i  in  32  fetch byte address
inst_o  out  32  fetched instruction, combinational
ld_start_i  in  1  begin load session (accepted only in IDLE)
ld_base_i  in  DEPTH_LOG2  starting word index, sampled with accepted ld_start_i
ld_valid_i  in  1  ld_byte_i valid
ld_byte_i  in  8  load data byte
ld_last_i  in  1  qualifies the final byte of the session
ld_ready_o  out  1  loader can accept a byte this cycle
ld_busy_o  out  1  session active (COLLECT or WRITE)
ld_count_o  out  DEPTH_LOG2+1  words committed in the current/last session
ld_err_o  out  1  sticky error for the current/last session

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, ld_ready_o=0, ld_busy_o=0, ld_count_o=0, ld_err_o=0, byte counter=0, shift register=0, write pointer=0. Memory array is not reset.
- Fetch read, combinational:
  - inst_o = mem[addr_i[DEPTH_LOG2+1:2]] when ce_i=1 and ld_busy_o=0; otherwise 0.
  - addr_i[1:0] and bits above DEPTH_LOG2+1 are ignored, so addresses alias modulo DEPTH words.
- State IDLE:
  - ld_ready_o=0, ld_busy_o=0.
  - ld_start_i=1 -> COLLECT. On the same edge: wptr<=ld_base_i, ld_count_o<=0, ld_err_o<=0, byte counter<=0.
- State COLLECT:
  - ld_ready_o=1. A byte is accepted on a clock edge where ld_valid_i and ld_ready_o are both 1.
  - Bytes pack big-endian: the first byte of a word goes to [31:24], the fourth to [7:0].
  - If the accepted byte is the 4th of the word, or ld_last_i=1: go to WRITE and latch the last flag.
  - On an early last (fewer than 4 bytes): the unfilled low bytes are zero, and ld_err_o<=1.
- State WRITE (exactly one cycle):
  - ld_ready_o=0.
  - If ld_count_o < DEPTH: mem[wptr]<=word, wptr<=wptr+1 (wraps modulo DEPTH), ld_count_o<=ld_count_o+1.
  - Else the write is suppressed and ld_err_o<=1 (overflow).
  - Byte counter and shift register clear.
  - Next state: IDLE if the latched last flag is set, else COLLECT.
- Latency: if the 4th byte is accepted at edge N, the word is written at edge N+1. For a last word, ld_busy_o falls after edge N+1 and the word is fetchable from then on.
- ld_start_i outside IDLE is ignored.
- ld_valid_i while ld_ready_o=0 is ignored; the producer must hold the byte.
- ld_err_o and ld_count_o hold their values in IDLE until the next accepted ld_start_i.
- Reset mid-session: return to IDLE immediately. Words already committed stay in memory; partial bytes are discarded.

Test Plan:
- Reset, then ld_start_i with base=0 and bytes 3C,01,12,34,34,21,00,FF (last on 8th) -> mem[0]=0x3C011234, mem[1]=0x342100FF, ld_count_o=2, ld_err_o=0; fetch addr 0x4 returns 0x342100FF.
- Fetch with ce_i=1 at addr 0x0 during a session -> inst_o=0; after ld_busy_o falls -> inst_o=0x3C011234. With ce_i=0 -> inst_o=0.
- Early last: base=5, bytes AA,BB,CC with last on CC -> mem[5]=0xAABBCC00, ld_err_o=1, ld_count_o=1.
- Overflow with DEPTH_LOG2=2: base=3, 5 words sent -> writes to indices 3,0,1,2; 5th word dropped; ld_count_o=4, ld_err_o=1; index 3 keeps the 1st word.
- Handshake: ld_valid_i held high continuously -> exactly one byte accepted per COLLECT cycle, none in WRITE cycles. ld_start_i pulsed mid-session -> no effect on wptr or ld_count_o.
- rst pulsed low after 6 bytes of an 8-byte load -> outputs return to reset values asynchronously; mem[0] holds the first word; ld_busy_o=0; fetch addr 0x1000 (with DEPTH_LOG2=10) aliases to index 0.
